// File: rtl/sat_event_monitor_if.sv
// Saturation-flag event and host read bundle for sat_event_monitor; irq member exists only with SAT_MON_IRQ_EN.
// Latency: none (wires only). Backpressure: none; rd_req is dropped while a read is outstanding.
// master = flag source and host, slave = monitor.
interface sat_event_monitor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 ev_valid;
    logic                 out_10;
    logic                 out_01;
    logic                 out_00;
    logic                 out_11;
    logic                 rd_req;
    logic [1:0]           rd_sel;
    logic                 rd_ack;
    logic [CNT_WIDTH-1:0] rd_data;
    logic [3:0]           sticky;
`ifdef SAT_MON_IRQ_EN
    logic                 irq;
`endif

    modport master (
        output ev_valid, out_10, out_01, out_00, out_11, rd_req, rd_sel,
        input  rd_ack, rd_data, sticky
`ifdef SAT_MON_IRQ_EN
        , input irq
`endif
    );

    modport slave (
        input  ev_valid, out_10, out_01, out_00, out_11, rd_req, rd_sel,
        output rd_ack, rd_data, sticky
`ifdef SAT_MON_IRQ_EN
        , output irq
`endif
    );
endinterface

// File: rtl/sat_event_monitor.sv
// Saturating per-flag event counters with sticky bits and a req/ack host read port; optional irq via SAT_MON_IRQ_EN.
// Latency: rd_req at cycle N gives rd_ack/rd_data at N+1; irq follows the counters by one cycle.
// Backpressure: none; events are never stalled, rd_req during the ack cycle is dropped without queueing.
module sat_event_monitor #(
    parameter int CNT_WIDTH = 8,
    parameter int CLR_ON_RD = 1
`ifdef SAT_MON_IRQ_EN
    , parameter int THRESH  = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    sat_event_monitor_if.slave   bus
);
    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt [4];
    logic [3:0]           ev;
    logic [3:0]           clr;
    logic [3:0]           sticky_q;
    logic                 rd_ack_q;
    logic [CNT_WIDTH-1:0] rd_data_q;

    assign ev = {4{bus.ev_valid}} & {bus.out_11, bus.out_00, bus.out_01, bus.out_10};

    always_comb begin
        clr = '0;
        if (CLR_ON_RD != 0 && state == IDLE && bus.rd_req)
            clr[bus.rd_sel] = 1'b1;
    end

    // An event in the same cycle as a clearing read wins: the counter restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++)
                cnt[k] <= '0;
            sticky_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ev[k]) begin
                    if (clr[k])
                        cnt[k] <= CNT_WIDTH'(1);
                    else if (cnt[k] != CNT_MAX)
                        cnt[k] <= cnt[k] + 1'b1;
                    sticky_q[k] <= 1'b1;
                end else if (clr[k]) begin
                    cnt[k]      <= '0;
                    sticky_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack_q <= 1'b0;
                    if (bus.rd_req) begin
                        rd_data_q <= cnt[bus.rd_sel];
                        rd_ack_q  <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    rd_ack_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    rd_ack_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;
    assign bus.sticky  = sticky_q;

`ifdef SAT_MON_IRQ_EN
    logic [3:0] over;
    logic       irq_q;

    always_comb begin
        over = '0;
        for (int k = 0; k < 4; k++)
            over[k] = {{(32-CNT_WIDTH){1'b0}}, cnt[k]} >= 32'(THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_q <= 1'b0;
        else
            irq_q <= |over;
    end

    assign bus.irq = irq_q;
`endif
endmodule
